// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with saturating direction counters
module branch_predictor #(
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2,
    parameter int MODE     = 1,
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PC_WIDTH-1:0] lookup_pc,
    output logic                pred_hit,
    output logic                pred_taken,
    output logic [PC_WIDTH-1:0] pred_target,
    input  logic                upd_valid,
    input  logic [PC_WIDTH-1:0] upd_pc,
    input  logic                upd_taken,
    input  logic [PC_WIDTH-1:0] upd_target,
    input  logic                upd_pred_taken,
    output logic                mispredict,
    output logic [31:0]         mispredict_cnt
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = PC_WIDTH - IDX - 2;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));

    logic                valid_q  [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [PC_WIDTH-1:0] target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

    logic        mispredict_q;
    logic [31:0] cnt_q, cnt_d;

    logic [IDX-1:0]      lk_idx, up_idx;
    logic [TAG_W-1:0]    lk_tag, up_tag;
    logic                up_hit, entry_we, mis;
    logic [CTR_BITS-1:0] cur_ctr, ctr_d;
    logic [PC_WIDTH-1:0] target_d;

    // Byte-offset bits never take part in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    always_comb begin
        lk_idx      = lookup_pc[IDX+1:2];
        lk_tag      = lookup_pc[PC_WIDTH-1:IDX+2];
        pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken  = (MODE != 0) && pred_hit && ctr_q[lk_idx][CTR_BITS-1];
        pred_target = pred_hit ? target_q[lk_idx] : '0;
    end

    always_comb begin
        up_idx   = upd_pc[IDX+1:2];
        up_tag   = upd_pc[PC_WIDTH-1:IDX+2];
        up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        cur_ctr  = ctr_q[up_idx];
        ctr_d    = cur_ctr;
        target_d = target_q[up_idx];
        // A not-taken branch that misses is never worth a slot.
        entry_we = upd_valid && (up_hit || upd_taken);
        if (up_hit) begin
            if (upd_taken) begin
                ctr_d    = (cur_ctr == CTR_MAX) ? cur_ctr : cur_ctr + CTR_BITS'(1);
                target_d = upd_target;
            end else begin
                ctr_d    = (cur_ctr == '0) ? cur_ctr : cur_ctr - CTR_BITS'(1);
            end
        end else begin
            ctr_d    = CTR_WEAK;
            target_d = upd_target;
        end
    end

    always_comb begin
        mis   = upd_valid && (upd_taken != upd_pred_taken);
        cnt_d = (mis && (cnt_q != '1)) ? cnt_q + 32'd1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= '0;
            end
            mispredict_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            if (entry_we) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= target_d;
                ctr_q[up_idx]    <= ctr_d;
            end
            mispredict_q <= mis;
            cnt_q        <= cnt_d;
        end
    end

    assign mispredict     = mispredict_q;
    assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for bimodal and static branch_predictor
module tb_branch_predictor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] lk_pc   [2];
    logic        hit     [2];
    logic        tkn     [2];
    logic [31:0] tgt     [2];
    logic        uv      [2];
    logic [31:0] upc     [2];
    logic        ut      [2];
    logic [31:0] utgt    [2];
    logic        upt     [2];
    logic        mis     [2];
    logic [31:0] cnt     [2];

    branch_predictor #(.ENTRIES(16), .CTR_BITS(2), .MODE(1), .PC_WIDTH(32)) dut_bim (
        .clk(clk), .rst_n(rst_n), .lookup_pc(lk_pc[0]),
        .pred_hit(hit[0]), .pred_taken(tkn[0]), .pred_target(tgt[0]),
        .upd_valid(uv[0]), .upd_pc(upc[0]), .upd_taken(ut[0]), .upd_target(utgt[0]),
        .upd_pred_taken(upt[0]), .mispredict(mis[0]), .mispredict_cnt(cnt[0])
    );

    branch_predictor #(.ENTRIES(16), .CTR_BITS(2), .MODE(0), .PC_WIDTH(32)) dut_sta (
        .clk(clk), .rst_n(rst_n), .lookup_pc(lk_pc[1]),
        .pred_hit(hit[1]), .pred_taken(tkn[1]), .pred_target(tgt[1]),
        .upd_valid(uv[1]), .upd_pc(upc[1]), .upd_taken(ut[1]), .upd_target(utgt[1]),
        .upd_pred_taken(upt[1]), .mispredict(mis[1]), .mispredict_cnt(cnt[1])
    );

    typedef struct {
        int          cyc;
        int          sel;
        logic        hit;
        logic        tkn;
        logic [31:0] tgt;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int id, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s vec%0d actual=%h required=%h", name, id, act, req);
        end
    endtask

    // Monitor: compares every expectation scheduled for the current cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            exp_t e;
            int   s;
            e = exp_q.pop_front();
            s = e.sel;
            chk("pred_hit",       e.cyc, {31'd0, hit[s]}, {31'd0, e.hit});
            chk("pred_taken",     e.cyc, {31'd0, tkn[s]}, {31'd0, e.tkn});
            chk("pred_target",    e.cyc, tgt[s], e.tgt);
            chk("mispredict",     e.cyc, {31'd0, mis[s]}, {31'd0, e.mis});
            chk("mispredict_cnt", e.cyc, cnt[s], e.cnt);
        end
    end

    // One vector per cycle: drive the selected DUT, idle the other, queue its expected outputs.
    task automatic vec(input int sel, input logic rst, input logic [31:0] lpc,
                       input logic v, input logic [31:0] pc, input logic t,
                       input logic [31:0] target, input logic pt,
                       input logic e_hit, input logic e_tkn, input logic [31:0] e_tgt,
                       input logic e_mis, input logic [31:0] e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst;
        for (int i = 0; i < 2; i++) begin
            lk_pc[i] = (i == sel) ? lpc    : 32'd0;
            uv[i]    = (i == sel) ? v      : 1'b0;
            upc[i]   = (i == sel) ? pc     : 32'd0;
            ut[i]    = (i == sel) ? t      : 1'b0;
            utgt[i]  = (i == sel) ? target : 32'd0;
            upt[i]   = (i == sel) ? pt     : 1'b0;
        end
        e.cyc = cyc; e.sel = sel;
        e.hit = e_hit; e.tkn = e_tkn; e.tgt = e_tgt; e.mis = e_mis; e.cnt = e_cnt;
        exp_q.push_back(e);
    endtask

    localparam logic [31:0] P = 32'h0040_0010;
    localparam logic [31:0] Q = 32'h0040_0050;
    localparam logic [31:0] R = 32'h0040_0090;
    localparam logic [31:0] T = 32'h0040_0100;
    localparam logic [31:0] U = 32'h0040_0200;
    localparam logic [31:0] V = 32'h0040_0300;

    initial begin
        for (int i = 0; i < 2; i++) begin
            lk_pc[i] = '0; uv[i] = 1'b0; upc[i] = '0; ut[i] = 1'b0; utgt[i] = '0; upt[i] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        //   sel rst lookup  v  upc t  target pt   hit tkn tgt mis cnt
        vec(0, 1, P, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        vec(0, 1, P, 1, P, 1, T, 0,   0, 0, 0, 0, 0);   // same-cycle update not visible
        vec(0, 1, P, 1, P, 0, 0, 1,   1, 1, T, 1, 1);   // ctr 2
        vec(0, 1, P, 1, P, 0, 0, 0,   1, 0, T, 1, 2);   // ctr 1
        vec(0, 1, P, 1, P, 0, 0, 0,   1, 0, T, 0, 2);   // ctr 0
        vec(0, 1, P, 1, P, 1, T, 0,   1, 0, T, 0, 2);   // ctr held at 0
        vec(0, 1, P, 1, P, 1, T, 0,   1, 0, T, 1, 3);   // ctr 1
        vec(0, 1, P, 1, P, 1, T, 1,   1, 1, T, 1, 4);   // ctr 2
        vec(0, 1, P, 1, P, 1, T, 1,   1, 1, T, 0, 4);   // ctr 3
        vec(0, 1, P, 1, P, 0, 0, 1,   1, 1, T, 0, 4);   // ctr held at 3
        vec(0, 1, P, 0, 0, 0, 0, 0,   1, 1, T, 1, 5);   // ctr 2 proves saturation
        vec(0, 1, Q, 1, Q, 1, U, 0,   0, 0, 0, 0, 5);   // alias allocate replaces P
        vec(0, 1, Q, 0, 0, 0, 0, 0,   1, 1, U, 1, 6);
        vec(0, 1, P, 0, 0, 0, 0, 0,   0, 0, 0, 0, 6);
        vec(0, 1, Q, 1, R, 0, 0, 0,   1, 1, U, 0, 6);   // not-taken miss ignored
        vec(0, 1, Q, 0, 0, 0, 0, 0,   1, 1, U, 0, 6);
        vec(0, 1, Q, 1, Q, 1, V, 1,   1, 1, U, 0, 6);   // hit taken retargets
        vec(0, 1, Q, 0, 0, 0, 0, 0,   1, 1, V, 0, 6);
        vec(0, 0, Q, 1, Q, 1, T, 0,   1, 1, V, 0, 6);   // update dropped by reset
        vec(0, 1, Q, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        vec(0, 1, P, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);

        vec(1, 1, P, 1, P, 1, T, 0,   0, 0, 0, 0, 0);
        vec(1, 1, P, 1, P, 1, T, 0,   1, 0, T, 1, 1);
        vec(1, 1, P, 1, P, 1, T, 0,   1, 0, T, 1, 2);
        vec(1, 1, P, 0, 0, 0, 0, 0,   1, 0, T, 1, 3);
        vec(1, 1, P, 0, 0, 0, 0, 0,   1, 0, T, 0, 3);

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
